// File: rtl/muse_pkg.sv
// Shared definitions for the rhythm-game chart playback blocks: controller
// states, chart entry lane layout and note codes.
package muse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNTIN = 3'd1,
    ST_PLAY    = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    NOTE_NONE = 2'd0,
    NOTE_TAP  = 2'd1,
    NOTE_HOLD = 2'd2,
    NOTE_RSVD = 2'd3
  } note_e;

  localparam int UP_LSB   = 2;
  localparam int DOWN_LSB = 0;

  function automatic logic [1:0] up_lane(input logic [3:0] entry);
    return entry[UP_LSB +: 2];
  endfunction

  function automatic logic [1:0] down_lane(input logic [3:0] entry);
    return entry[DOWN_LSB +: 2];
  endfunction

endpackage

// File: rtl/note_scheduler_step_timer.sv
// Chart step divider: counts 0..STEP_DIV-1 while running, freezes otherwise,
// and flags the last count of each step.
module step_timer #(
  parameter int STEP_DIV = 8
) (
  input  logic clk_div,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic at_end
);

  localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

  logic [7:0] div_cnt_r;

  assign at_end = (div_cnt_r == LAST);

  // Divider counter with synchronous clear and freeze
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= 8'd0;
    end else if (clr) begin
      div_cnt_r <= 8'd0;
    end else if (run) begin
      div_cnt_r <= at_end ? 8'd0 : div_cnt_r + 8'd1;
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Chart playback controller: walks a chart ROM one entry per step after a
// count-in, emitting one-cycle up/down lane note codes for the note queue.
module note_scheduler
  import muse_pkg::*;
#(
  parameter int STEP_DIV      = 8,
  parameter int CHART_LEN     = 256,
  parameter int ADDR_W        = 8,
  parameter int COUNTIN_STEPS = 4
) (
  input  logic              clk_div,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [1:0]        noteup,
  output logic [1:0]        notedown,
  output logic              step_pulse,
  output logic              playing,
  output logic              song_done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CHART_LEN - 1);
  localparam logic [7:0]        CIN_LAST  = (COUNTIN_STEPS > 0) ? 8'(COUNTIN_STEPS - 1) : 8'd0;

  state_e            state_r, state_nxt;
  logic              resume_play_r, resume_play_nxt;
  logic [7:0]        cin_cnt_r, cin_cnt_nxt;
  logic [ADDR_W-1:0] rom_addr_nxt;
  logic [1:0]        noteup_nxt, notedown_nxt;
  logic              pulse_nxt, timer_clr, timer_run, at_end, play_ctx;

  step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
    .clk_div (clk_div),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .run     (timer_run),
    .at_end  (at_end)
  );

  // Next-state, counters and note outputs
  always_comb begin
    state_nxt       = state_r;
    resume_play_nxt = resume_play_r;
    cin_cnt_nxt     = cin_cnt_r;
    rom_addr_nxt    = rom_addr;
    noteup_nxt      = NOTE_NONE;
    notedown_nxt    = NOTE_NONE;
    pulse_nxt       = 1'b0;
    timer_clr       = 1'b0;
    timer_run       = 1'b0;
    // Leaving PAUSE counts in the context it was paused from
    play_ctx        = (state_r == ST_PLAY) || ((state_r == ST_PAUSE) && resume_play_r);
    if (restart) begin
      state_nxt    = ST_IDLE;
      cin_cnt_nxt  = 8'd0;
      rom_addr_nxt = '0;
      timer_clr    = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !pause) begin
            timer_clr   = 1'b1;
            cin_cnt_nxt = 8'd0;
            state_nxt   = (COUNTIN_STEPS > 0) ? ST_COUNTIN : ST_PLAY;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_COUNTIN, ST_PLAY: begin
          if (pause) begin
            state_nxt       = ST_PAUSE;
            resume_play_nxt = (state_r == ST_PLAY);
          end else begin
            timer_run = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            timer_run = 1'b1;
            state_nxt = resume_play_r ? ST_PLAY : ST_COUNTIN;
          end else begin
            state_nxt = ST_PAUSE;
          end
        end
        ST_DONE:  state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
      if (timer_run && at_end) begin
        pulse_nxt = 1'b1;
        if (play_ctx) begin
          noteup_nxt   = up_lane(rom_data);
          notedown_nxt = down_lane(rom_data);
          if (rom_addr == ADDR_LAST) begin
            state_nxt = ST_DONE;
          end else begin
            rom_addr_nxt = rom_addr + ADDR_W'(1);
          end
        end else begin
          if (cin_cnt_r == CIN_LAST) begin
            state_nxt   = ST_PLAY;
            cin_cnt_nxt = 8'd0;
          end else begin
            cin_cnt_nxt = cin_cnt_r + 8'd1;
          end
        end
      end else begin
        pulse_nxt = 1'b0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      resume_play_r <= 1'b0;
      cin_cnt_r     <= 8'd0;
      rom_addr      <= '0;
      noteup        <= 2'd0;
      notedown      <= 2'd0;
      step_pulse    <= 1'b0;
      playing       <= 1'b0;
      song_done     <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      resume_play_r <= resume_play_nxt;
      cin_cnt_r     <= cin_cnt_nxt;
      rom_addr      <= rom_addr_nxt;
      noteup        <= noteup_nxt;
      notedown      <= notedown_nxt;
      step_pulse    <= pulse_nxt;
      playing       <= (state_nxt == ST_COUNTIN) || (state_nxt == ST_PLAY);
      song_done     <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter STEP_DIV, 8: clk_div cycles per chart step; legal range 2..255.
REQ-002 Parameter CHART_LEN, 256: number of chart entries; legal range 1..2**ADDR_W.
REQ-003 Parameter ADDR_W, 8: chart ROM address width.
REQ-004 Parameter COUNTIN_STEPS, 4: empty lead-in steps before the first chart entry; legal range 0..255.
REQ-005 clk_div  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  level; begins playback from IDLE.
REQ-008 pause  in  1  level; freezes playback while high.
REQ-009 restart  in  1  level; synchronous return to IDLE.
REQ-010 rom_addr  out  ADDR_W  chart ROM read address (registered).
REQ-011 rom_data  in  4  chart entry: [3:2] up lane, [1:0] down lane; valid 1 cycle after rom_addr changes.
REQ-012 noteup  out  2  up-lane note code for the note queue (registered).
REQ-013 notedown  out  2  down-lane note code for the note queue (registered).
REQ-014 step_pulse  out  1  one-cycle strobe marking a chart step (registered).
REQ-015 playing  out  1  high in COUNTIN or PLAY.
REQ-016 song_done  out  1  high in DONE.

Function
REQ-017 States are IDLE, COUNTIN, PLAY, PAUSE and DONE, one-hot or binary encoded.
REQ-018 Command priority is restart > pause > start; these are the only commands.
REQ-019 restart in any state: next state IDLE; rom_addr, div_cnt and cin_cnt are cleared to 0; noteup, notedown and step_pulse are 0 next cycle.
REQ-020 IDLE with start=1 and pause=0: go to COUNTIN when COUNTIN_STEPS>0, otherwise go to PLAY; div_cnt is cleared to 0.
REQ-021 div_cnt counts 0..STEP_DIV-1 and wraps in COUNTIN and PLAY; a step occurs in the cycle where div_cnt==STEP_DIV-1.
REQ-022 A step registers step_pulse=1 for exactly the next cycle; step_pulse is 0 in every other cycle.
REQ-023 COUNTIN step: noteup=notedown=0, cin_cnt increments; the step with cin_cnt==COUNTIN_STEPS-1 goes to PLAY.
REQ-024 PLAY step: noteup<=rom_data[3:2] and notedown<=rom_data[1:0], both held for one cycle only; rom_addr increments.
REQ-025 PLAY step with rom_addr==CHART_LEN-1: the entry is emitted, rom_addr is not incremented, and the state goes to DONE.
REQ-026 Outside a PLAY step cycle, noteup and notedown are 0.
REQ-027 pause=1 in COUNTIN or PLAY: go to PAUSE; div_cnt, cin_cnt and rom_addr freeze, and the step due in that cycle is suppressed.
REQ-028 PAUSE with pause=0: return to the state it was paused from, with div_cnt resuming from its frozen value; start is ignored in PAUSE.
REQ-029 DONE holds until restart; start and pause are ignored.
REQ-030 rom_addr is stable for at least STEP_DIV cycles before each PLAY step, so rom_data is always valid when sampled.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, rom_addr=0, div_cnt=0, cin_cnt=0, noteup=0, notedown=0, step_pulse=0, playing=0, song_done=0.
REQ-032 Reset asserted mid-playback discards the current position; there is no resume after reset.

Structure
REQ-033 The state encoding, the rom_data lane field positions and the 2-bit note codes (0 = none, 1 = tap, 2 = hold, 3 = reserved) belong in a shared package named muse_pkg.
REQ-034 The step divider (div_cnt with freeze input and wrap strobe) is the one natural sub-module: step_timer.
REQ-035 The block is single clock domain; start, pause and restart are already synchronous to clk_div.

Verification
REQ-036 STEP_DIV=4, COUNTIN_STEPS=2, start pulse -> step_pulse at cycles 4,8,12,...; noteup=notedown=0 on the first 2 steps; the first ROM entry appears on the 3rd step.
REQ-037 ROM[0]=4'b0110, ROM[1]=4'b1001 -> step 1 gives noteup=01 and notedown=10; step 2 gives noteup=10 and notedown=01; each is high for one cycle.
REQ-038 CHART_LEN=3 -> 3 note steps, then song_done=1 and step_pulse stays 0 for 20+ cycles; rom_addr holds 2.
REQ-039 pause raised when div_cnt==2 and held 10 cycles (STEP_DIV=4) -> no step_pulse during PAUSE; the next step occurs 1 cycle after pause falls; rom_addr is unchanged.
REQ-040 restart and pause asserted together in PLAY -> IDLE next cycle, rom_addr=0; a later start replays from ROM[0].
REQ-041 rst_n pulsed low mid-PLAY asynchronously -> all outputs 0 immediately; start is then required to play again.
